mealy_pattern_multi: RTL and testbench

Parametrised Mealy sequence detector. It is the successor of the fixed 3-bit 101/010 detector. It compares a sliding window of the serial input `i` against two run-time programmable patterns of length LEN, and flags each match combinationally in the same cycle as the completing bit. It adds enable, synchronous clear, an overlap/non-overlap mode and optional saturating match counters, and sits directly on a serial bit stream as a monitor.

---
 rtl/mealy_pattern_multi.sv | 148 ++++++++++++++
 tb/tb_mealy_pattern_multi.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mealy_pattern_multi.sv
// Sliding-window Mealy detector: flags matches of two programmable LEN-bit patterns on a serial stream.
// Optional saturating per-pattern match counters are enabled by defining MEALY_PATTERN_COUNT_EN.
module mealy_pattern_multi #(
    parameter int LEN   = 3,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clear,
    input  logic             overlap,
    input  logic             i,
    input  logic [LEN-1:0]   pattern_a,
    input  logic [LEN-1:0]   pattern_b,
    output logic [1:0]       o,
    output logic             armed
`ifdef MEALY_PATTERN_COUNT_EN
    ,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
`endif
);

    localparam int             FW       = (LEN > 2) ? $clog2(LEN) : 1;
    localparam logic [FW-1:0]  FILL_MAX = FW'(LEN - 1);

    typedef enum logic {
        S_FILL  = 1'b0,
        S_ARMED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [LEN-2:0]   hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [LEN-1:0]   window_s;
    logic             match_a_s;
    logic             match_b_s;
    logic             armed_s;

    // The FSM state is kept in lockstep with fill so armed comes straight from a flop.
    assign armed_s  = (state_q == S_ARMED);
    assign window_s = {hist_q, i};

    // Combinational compare; patterns feed the comparator directly so a change shows up at once.
    always_comb begin
        match_a_s = 1'b0;
        match_b_s = 1'b0;
        if (en && armed_s && !clear) begin
            match_a_s = (window_s == pattern_a);
            match_b_s = (window_s == pattern_b);
        end else begin
            match_a_s = 1'b0;
            match_b_s = 1'b0;
        end
    end

    assign o     = {match_a_s, match_b_s};
    assign armed = armed_s;

    // Next-state for history, fill level and FSM state, in clear > hold > restart > shift priority.
    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        state_d = state_q;
        if (clear) begin
            hist_d  = '0;
            fill_d  = '0;
            state_d = S_FILL;
        end else if (!en) begin
            hist_d  = hist_q;
            fill_d  = fill_q;
            state_d = state_q;
        end else if (!overlap && (match_a_s || match_b_s)) begin
            // The window keeps shifting, but a fresh match must wait for LEN new bits.
            hist_d  = window_s[LEN-2:0];
            fill_d  = '0;
            state_d = S_FILL;
        end else begin
            hist_d = window_s[LEN-2:0];
            if (fill_q == FILL_MAX) begin
                fill_d = fill_q;
            end else begin
                fill_d = fill_q + FW'(1'b1);
            end
            if (fill_d == FILL_MAX) begin
                state_d = S_ARMED;
            end else begin
                state_d = S_FILL;
            end
        end
    end

    // Detector FSM, history and fill registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FILL;
            hist_q  <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
        end
    end

`ifdef MEALY_PATTERN_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

    // Saturating match counters; matches are already suppressed while clear or en is inactive.
    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (clear) begin
            cnt_a_d = '0;
            cnt_b_d = '0;
        end else begin
            if (match_a_s && (cnt_a_q != CNT_MAX)) begin
                cnt_a_d = cnt_a_q + CNT_W'(1'b1);
            end else begin
                cnt_a_d = cnt_a_q;
            end
            if (match_b_s && (cnt_b_q != CNT_MAX)) begin
                cnt_b_d = cnt_b_q + CNT_W'(1'b1);
            end else begin
                cnt_b_d = cnt_b_q;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign cnt_a = cnt_a_q;
    assign cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_mealy_pattern_multi.sv
// Scoreboard bench for mealy_pattern_multi: directed scenarios plus randomized traffic,
// expectations from a bit-history model kept in queues.
module tb_mealy_pattern_multi;

    localparam int L  = 3;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic           clock;
    logic           reset_n;
    logic           en;
    logic           clear;
    logic           overlap;
    logic           i;
    logic [L-1:0]   pattern_a;
    logic [L-1:0]   pattern_b;
    logic [1:0]     o;
    logic           armed;
`ifdef MEALY_PATTERN_COUNT_EN
    logic [CW-1:0]  cnt_a;
    logic [CW-1:0]  cnt_b;
`endif

    mealy_pattern_multi #(.LEN(L), .CNT_W(CW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .en        (en),
        .clear     (clear),
        .overlap   (overlap),
        .i         (i),
        .pattern_a (pattern_a),
        .pattern_b (pattern_b),
        .o         (o),
        .armed     (armed)
`ifdef MEALY_PATTERN_COUNT_EN
        ,
        .cnt_a     (cnt_a),
        .cnt_b     (cnt_b)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] o;
        logic       armed;
        int         ca;
        int         cb;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    // Reference model: queue of accepted bits, count of fresh bits since restart, match counts.
    int   hq[$];
    int   fresh;
    int   ca_m;
    int   cb_m;
    int   pa;
    int   pb;

    task automatic model_reset();
        hq.delete();
        for (int k = 0; k < L - 1; k++) hq.push_back(0);
        fresh = 0;
        ca_m  = 0;
        cb_m  = 0;
    endtask

    // One cycle: drive inputs on the falling edge, queue the expected response, advance the model.
    task automatic step(input bit rn, input bit e, input bit c, input bit ov, input bit b,
                        input int exp_o, input string tag);
        int   win;
        bit   arm;
        bit   ma;
        bit   mb;
        exp_t x;
        @(negedge clock);
        reset_n   = rn;
        en        = e;
        clear     = c;
        overlap   = ov;
        i         = b;
        pattern_a = pa[L-1:0];
        pattern_b = pb[L-1:0];
        if (!rn) model_reset();
        win = 0;
        for (int k = 0; k < L - 1; k++) win = win * 2 + hq[k];
        win = win * 2 + int'(b);
        arm = (fresh >= L - 1);
        ma  = rn && e && !c && arm && (win == pa);
        mb  = rn && e && !c && arm && (win == pb);
        x.o     = (exp_o >= 0) ? exp_o[1:0] : {ma, mb};
        x.armed = arm;
        x.ca    = ca_m;
        x.cb    = cb_m;
        x.tag   = tag;
        #1;
        sb.push_back(x);
        if (!rn) begin
            model_reset();
        end else if (c) begin
            model_reset();
        end else if (e) begin
            hq.push_back(int'(b));
            void'(hq.pop_front());
            if (!ov && (ma || mb)) fresh = 0;
            else if (fresh < L - 1) fresh++;
            if (ma && ca_m < CMAX) ca_m++;
            if (mb && cb_m < CMAX) cb_m++;
        end
    endtask

    // Monitor: pops one expectation per cycle, well clear of the rising edge.
    always @(negedge clock) begin
        exp_t x;
        #3;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            checks++;
            if (o === x.o) passes++;
            else $display("FAIL %s o: got %b expected %b at %0t", x.tag, o, x.o, $time);
            checks++;
            if (armed === x.armed) passes++;
            else $display("FAIL %s armed: got %b expected %b at %0t", x.tag, armed, x.armed, $time);
`ifdef MEALY_PATTERN_COUNT_EN
            checks++;
            if (int'(cnt_a) == x.ca && int'(cnt_b) == x.cb) passes++;
            else $display("FAIL %s cnt: got %0d/%0d expected %0d/%0d at %0t",
                          x.tag, cnt_a, cnt_b, x.ca, x.cb, $time);
`endif
        end
    end

    initial begin
        int fill_seq[5]   = '{0, 1, 0, 1, 0};
        int fill_exp[5]   = '{0, 0, 1, 2, 1};
        int novl_seq[6]   = '{0, 1, 0, 1, 0, 1};
        int novl_exp[6]   = '{0, 0, 1, 0, 0, 2};
        int wait_cnt;
        reset_n = 1'b0; en = 1'b0; clear = 1'b0; overlap = 1'b1; i = 1'b0;
        pa = 5; pb = 2;
        pattern_a = 3'b101; pattern_b = 3'b010;
        model_reset();

        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, "reset");
        for (int k = 0; k < 5; k++)
            step(1'b1, 1'b1, 1'b0, 1'b1, fill_seq[k][0], fill_exp[k], "fill_overlap");

        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, "reset2");
        for (int k = 0; k < 6; k++)
            step(1'b1, 1'b1, 1'b0, 1'b0, novl_seq[k][0], novl_exp[k], "non_overlap");

        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, "reset3");
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, "en_gate");
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, "en_gate");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, "en_low");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, "en_low");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, "en_low");
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2, "en_resume");

        // Clear while armed with a would-be match on i.
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, "clear");
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, "after_clear");
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, "after_clear");
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2, "after_clear");
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, "reset_mid");

        pa = 6; pb = 6;
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, "identical");
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, "identical");
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3, "identical");

        // Saturation run: every bit of a constant stream matches once armed.
        pa = 7; pb = 7;
        for (int k = 0; k < 7; k++)
            step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, -1, "saturate");

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                pa = int'($urandom_range(0, (1 << L) - 1));
                pb = ($urandom_range(0, 3) == 0) ? pa : int'($urandom_range(0, (1 << L) - 1));
            end
            step(($urandom_range(0, 79) != 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, -1, "random");
        end

        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 10) begin
            @(negedge clock);
            wait_cnt++;
        end
        #5;
        checks++;
        if (sb.size() == 0) passes++;
        else $display("FAIL drain: got %0d pending expected 0", sb.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
